// File: rtl/sd_pkg.sv
// Shared constants and types for the SD-card SPI PHY.
// Holds SCK half-period defaults and transfer bit counts.
package sd_pkg;

  localparam int SLOW_HALF_DEF = 63;
  localparam int FAST_HALF_DEF = 1;
  localparam int BYTE_BITS     = 8;
  localparam int WIDE_BITS     = 32;

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } spi_st_e;

  function automatic int cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period counter for the SPI PHY.
// Emits one-cycle strobes at the end of each low/high phase.
module spi_sck_gen
  import sd_pkg::*;
#(
  parameter int SLOW_HALF = SLOW_HALF_DEF,
  parameter int FAST_HALF = FAST_HALF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic fast,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(SLOW_HALF, FAST_HALF);
  localparam logic [CW-1:0] SLIM = CW'(SLOW_HALF - 1);
  localparam logic [CW-1:0] FLIM = CW'(FAST_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lim;
  logic          ph_q, ph_d;
  logic          hit;

  // ph_q=0 is the low half of a bit, ph_q=1 the high half
  always_comb begin
    lim   = fast ? FLIM : SLIM;
    hit   = run && (cnt_q == lim);
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (clr) begin
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (hit) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise = hit & ~ph_q;
  assign fall = hit & ph_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/spi_phy.sv
// Mode-0 SPI master PHY for SD cards: 8/32-bit transfers,
// two SCK speeds, registered pins.
module spi_phy
  import sd_pkg::*;
#(
  parameter int SLOW_HALF = SLOW_HALF_DEF,
  parameter int FAST_HALF = FAST_HALF_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] spi_mosi,
  input  logic        spi_begin,
  input  logic        spi_wide,
  input  logic        spi_cs,
  input  logic        spi_fast,
  output logic [31:0] spi_miso,
  output logic        spi_busy,
  output logic        sd_sck,
  output logic        sd_mosi,
  input  logic        sd_miso,
  output logic        sd_cs_n
);

  spi_st_e     st_q;
  logic        wide_q;
  logic        fast_q;
  logic [31:0] tx_q;
  logic [31:0] rx_q;
  logic [31:0] miso_q;
  logic [5:0]  bits_q;
  logic        sck_q;
  logic        mosi_q;
  logic        cs_q;
  logic        start;
  logic        rise;
  logic        fall;
  logic [31:0] tx_load;

  assign start   = (st_q == ST_IDLE) && spi_begin;
  assign tx_load = spi_wide ? spi_mosi
                            : {spi_mosi[7:0], 24'h0};

  spi_sck_gen #(
    .SLOW_HALF(SLOW_HALF),
    .FAST_HALF(FAST_HALF)
  ) u_sck (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .run (st_q == ST_XFER),
    .fast(fast_q),
    .rise(rise),
    .fall(fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      wide_q <= 1'b0;
      fast_q <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
      miso_q <= '0;
      bits_q <= '0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b1;
      cs_q   <= 1'b1;
    end else begin
      cs_q <= spi_cs;
      unique case (st_q)
        ST_IDLE: begin
          if (spi_begin) begin
            st_q   <= ST_XFER;
            wide_q <= spi_wide;
            fast_q <= spi_fast;
            tx_q   <= tx_load;
            mosi_q <= tx_load[31];
            rx_q   <= '0;
            bits_q <= spi_wide ? 6'(WIDE_BITS)
                               : 6'(BYTE_BITS);
          end
        end
        ST_XFER: begin
          if (rise) begin
            sck_q <= 1'b1;
            rx_q  <= {rx_q[30:0], sd_miso};
          end
          // fall closes a bit; the last one ends the transfer
          if (fall) begin
            sck_q  <= 1'b0;
            tx_q   <= {tx_q[30:0], 1'b0};
            bits_q <= bits_q - 1'b1;
            if (bits_q == 6'd1) begin
              st_q   <= ST_IDLE;
              mosi_q <= 1'b1;
              miso_q <= wide_q ? rx_q
                               : {24'h0, rx_q[7:0]};
            end else begin
              mosi_q <= tx_q[30];
            end
          end
        end
      endcase
    end
  end

  assign spi_miso = miso_q;
  assign spi_busy = (st_q == ST_XFER);
  assign sd_sck   = sck_q;
  assign sd_mosi  = mosi_q;
  assign sd_cs_n  = cs_q;

endmodule

// File: tb/tb_spi_phy.sv
// Self-checking bench for spi_phy with a queue-based slave
// model and randomized byte/word transfers.
module tb_spi_phy;

  localparam int SH = 63;
  localparam int FH = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] spi_mosi;
  logic        spi_begin;
  logic        spi_wide;
  logic        spi_cs;
  logic        spi_fast;
  logic [31:0] spi_miso;
  logic        spi_busy;
  logic        sd_sck;
  logic        sd_mosi;
  logic        sd_miso;
  logic        sd_cs_n;

  always #5 clk = ~clk;

  spi_phy #(
    .SLOW_HALF(SH),
    .FAST_HALF(FH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_mosi (spi_mosi),
    .spi_begin(spi_begin),
    .spi_wide (spi_wide),
    .spi_cs   (spi_cs),
    .spi_fast (spi_fast),
    .spi_miso (spi_miso),
    .spi_busy (spi_busy),
    .sd_sck   (sd_sck),
    .sd_mosi  (sd_mosi),
    .sd_miso  (sd_miso),
    .sd_cs_n  (sd_cs_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  bit sq[$];
  bit mq[$];

  // slave shifts out its next bit after every SCK fall
  always @(negedge sd_sck)
    if (sq.size() > 0) sd_miso = sq.pop_front();

  always @(posedge sd_sck) mq.push_back(sd_mosi);

  bit  meas = 0;
  time t_r = 0;
  time t_f = 0;
  int  nhi = 0, nlo = 0, hi_bad = 0, lo_bad = 0;

  always @(posedge sd_sck) begin
    if (meas && t_f != 0) begin
      nlo++;
      if ($time - t_f != SH * 10) lo_bad++;
    end
    t_r = $time;
  end

  always @(negedge sd_sck) begin
    if (meas) begin
      nhi++;
      if ($time - t_r != SH * 10) hi_bad++;
    end
    t_f = $time;
  end

  task automatic fill_slave(input logic [31:0] w,
                            input bit wide);
    int nb;
    nb = wide ? 32 : 8;
    sq.delete();
    for (int i = nb - 1; i >= 0; i--) sq.push_back(w[i]);
    sd_miso = sq.pop_front();
  endtask

  // called at a negedge; returns at T+1 plus 1ns
  task automatic start(input logic [31:0] tx,
                       input bit wide,
                       input bit fast,
                       input logic [31:0] slv,
                       input bit hold);
    spi_mosi  = tx;
    spi_wide  = wide;
    spi_fast  = fast;
    spi_begin = 1'b1;
    mq.delete();
    fill_slave(slv, wide);
    @(posedge clk);
    #1;
    if (!hold) spi_begin = 1'b0;
  endtask

  task automatic finish(input string tag,
                        input logic [31:0] tx,
                        input bit wide,
                        input bit fast,
                        input logic [31:0] slv,
                        input bit disturb);
    int n, nb, half;
    logic [31:0] got_tx, exp_tx, exp_rx;
    bit prev_cs;
    nb     = wide ? 32 : 8;
    half   = fast ? FH : SH;
    exp_tx = wide ? tx : {24'h0, tx[7:0]};
    exp_rx = wide ? slv : {24'h0, slv[7:0]};
    chk({tag, ".busy1"}, {31'h0, spi_busy}, 32'd1);
    chk({tag, ".msb"}, {31'h0, sd_mosi},
        {31'h0, exp_tx[nb-1]});
    n = 0;
    prev_cs = spi_cs;
    @(negedge clk);
    while (spi_busy && n < 5000) begin
      n++;
      if (disturb && n == 5) begin
        spi_mosi  = ~spi_mosi;
        spi_wide  = ~spi_wide;
        spi_fast  = ~spi_fast;
        spi_begin = 1'b1;
        prev_cs   = ~spi_cs;
        spi_cs    = prev_cs;
      end
      if (disturb && n == 6) begin
        spi_begin = 1'b0;
        chk({tag, ".cs_busy"}, {31'h0, sd_cs_n},
            {31'h0, prev_cs});
      end
      @(negedge clk);
    end
    got_tx = '0;
    foreach (mq[i]) got_tx = {got_tx[30:0], mq[i]};
    chk({tag, ".len"}, n, nb * 2 * half);
    chk({tag, ".nbits"}, mq.size(), nb);
    chk({tag, ".mosi"}, got_tx, exp_tx);
    chk({tag, ".miso"}, spi_miso, exp_rx);
    chk({tag, ".sck0"}, {31'h0, sd_sck}, 32'd0);
    chk({tag, ".idle1"}, {31'h0, sd_mosi}, 32'd1);
  endtask

  logic [31:0] tx, slv;
  bit          wd;
  int          n;

  initial begin
    rst = 1'b1;
    spi_mosi = '0;
    spi_begin = 1'b0;
    spi_wide = 1'b0;
    spi_cs = 1'b0;
    spi_fast = 1'b1;
    sd_miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", {31'h0, spi_busy}, 32'd0);
    chk("rst.miso", spi_miso, 32'd0);
    chk("rst.sck", {31'h0, sd_sck}, 32'd0);
    chk("rst.mosi", {31'h0, sd_mosi}, 32'd1);
    chk("rst.cs", {31'h0, sd_cs_n}, 32'd1);

    rst = 1'b0;
    spi_cs = 1'b1;
    start(32'h0000_0040, 1'b0, 1'b1, 32'h0000_00A5, 1'b0);
    finish("byte40", 32'h40, 1'b0, 1'b1, 32'hA5, 1'b0);
    chk("cs.follow", {31'h0, sd_cs_n}, 32'd1);

    start(32'hFFFF_FFFF, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    finish("wideFF", 32'hFFFF_FFFF, 1'b1, 1'b1,
           32'h1234_5678, 1'b0);

    for (int k = 0; k < 16; k++) begin
      tx  = $urandom;
      slv = $urandom;
      wd  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start(tx, wd, 1'b1, slv, 1'b0);
      finish($sformatf("rnd%0d", k), tx, wd, 1'b1, slv, 1'b0);
    end

    tx = $urandom;
    slv = $urandom;
    start(tx, 1'b0, 1'b1, slv, 1'b1);
    finish("b2b.a", tx, 1'b0, 1'b1, slv, 1'b0);
    chk("b2b.gap", {31'h0, spi_busy}, 32'd0);
    mq.delete();
    fill_slave(~slv, 1'b0);
    @(posedge clk);
    #1;
    spi_begin = 1'b0;
    finish("b2b.b", tx, 1'b0, 1'b1, ~slv, 1'b0);

    tx = $urandom;
    slv = $urandom;
    start(tx, 1'b1, 1'b1, slv, 1'b0);
    finish("dist", tx, 1'b1, 1'b1, slv, 1'b1);
    repeat (3) @(negedge clk);
    chk("dist.nostart", {31'h0, spi_busy}, 32'd0);

    start(32'h0000_00C3, 1'b0, 1'b1, 32'h0000_003C, 1'b0);
    n = 0;
    while (mq.size() < 3 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("abort.reach", {31'h0, n < 200}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.busy", {31'h0, spi_busy}, 32'd0);
    chk("abort.sck", {31'h0, sd_sck}, 32'd0);
    chk("abort.mosi", {31'h0, sd_mosi}, 32'd1);
    chk("abort.cs", {31'h0, sd_cs_n}, 32'd1);
    chk("abort.miso", spi_miso, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sq.delete();
    start(32'h0000_005A, 1'b0, 1'b1, 32'h0000_0081, 1'b0);
    finish("postrst", 32'h5A, 1'b0, 1'b1, 32'h81, 1'b0);

    meas = 1;
    t_f = 0;
    start(32'h0000_0096, 1'b0, 1'b0, 32'h0000_0069, 1'b0);
    finish("slow", 32'h96, 1'b0, 1'b0, 32'h69, 1'b0);
    meas = 0;
    chk("slow.nhi", nhi, 8);
    chk("slow.nlo", nlo, 7);
    chk("slow.hibad", hi_bad, 0);
    chk("slow.lobad", lo_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
